// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction fetch controller:
// fetch state encoding, default bus widths, PC step and reset PC.
package cpu_pkg;

    localparam int FETCH_ADDR_WIDTH = 10;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_PC_STEP    = 4;
    localparam int FETCH_RESET_PC   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of control, memory and decode-side signals of the fetch controller.
// master: the CPU/testbench side driving control and memory data.
// slave:  the fetch controller itself.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  halt_req;
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [DATA_WIDTH-1:0] imem_q;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  busy;

    modport master (
        output start, halt_req, stall, redirect_valid, redirect_pc, imem_q,
        input  imem_address, inst_valid, inst, inst_pc, busy
    );

    modport slave (
        input  start, halt_req, stall, redirect_valid, redirect_pc, imem_q,
        output imem_address, inst_valid, inst, inst_pc, busy
    );
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid register: captures the ROM word that is on the output when
// decode stalls, holds it until decode accepts it, and is dropped on flush.
module fetch_skid #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  pend,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  skid_valid,
    output logic [DATA_WIDTH-1:0] skid_data,
    output logic [ADDR_WIDTH-1:0] skid_pc
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [ADDR_WIDTH-1:0] pc_r;

    // Capture / hold / release of the single skid entry; flush wins over all.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (valid_r && !stall) begin
            // Entry is presented and accepted this cycle.
            valid_r <= 1'b0;
        end else if (stall && pend && !valid_r) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
            pc_r    <= in_pc;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign skid_valid = valid_r;
    assign skid_data  = data_r;
    assign skid_pc    = pc_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences a one-cycle-latency
// ROM, hides that latency behind a one-entry skid buffer, and handles
// start/halt control and branch redirects.
module inst_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int RESET_PC   = FETCH_RESET_PC,
    parameter int PC_STEP    = FETCH_PC_STEP
) (
    input  logic               clock,
    input  logic               reset_n,
    inst_fetch_ctrl_if.slave   bus
);

    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  pend_r;
    logic [ADDR_WIDTH-1:0] pend_pc_r;
    logic                  issue_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic                  skid_valid_s;
    logic [DATA_WIDTH-1:0] skid_data_s;
    logic [ADDR_WIDTH-1:0] skid_pc_s;

    // Issue decision and word-aligned redirect target.
    always_comb begin
        issue_s  = 1'b0;
        target_s = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        if (state_r == RUN) begin
            issue_s = !bus.halt_req && !bus.redirect_valid &&
                      !(bus.stall && (pend_r || skid_valid_s));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic; a redirect keeps the state except that it ends a drain.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.redirect_valid) begin
            if (state_r == DRAIN) begin
                state_nxt_s = IDLE;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) state_nxt_s = RUN;
                    else           state_nxt_s = IDLE;
                end
                RUN: begin
                    if (bus.halt_req) state_nxt_s = DRAIN;
                    else              state_nxt_s = RUN;
                end
                DRAIN: begin
                    if (!pend_r && !skid_valid_s) state_nxt_s = IDLE;
                    else                          state_nxt_s = DRAIN;
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, PC and in-flight ROM read tracking.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            pc_r      <= ADDR_WIDTH'(RESET_PC);
            pend_r    <= 1'b0;
            pend_pc_r <= ADDR_WIDTH'(RESET_PC);
        end else begin
            state_r <= state_nxt_s;
            if (bus.redirect_valid) begin
                pc_r   <= target_s;
                pend_r <= 1'b0;
            end else if (issue_s) begin
                pend_pc_r <= pc_r;
                pend_r    <= 1'b1;
                pc_r      <= pc_r + ADDR_WIDTH'(PC_STEP);
            end else begin
                pend_r <= 1'b0;
            end
        end
    end

    fetch_skid #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (bus.redirect_valid),
        .stall      (bus.stall),
        .pend       (pend_r),
        .in_data    (bus.imem_q),
        .in_pc      (pend_pc_r),
        .skid_valid (skid_valid_s),
        .skid_data  (skid_data_s),
        .skid_pc    (skid_pc_s)
    );

    // Output mux: the skid entry is older than the ROM word, so it goes first.
    always_comb begin
        bus.inst       = bus.imem_q;
        bus.inst_pc    = pend_pc_r;
        bus.inst_valid = (skid_valid_s || pend_r) && !bus.redirect_valid;
        if (skid_valid_s) begin
            bus.inst    = skid_data_s;
            bus.inst_pc = skid_pc_s;
        end else begin
            bus.inst    = bus.imem_q;
            bus.inst_pc = pend_pc_r;
        end
    end

    assign bus.imem_address = pc_r;
    assign bus.busy         = (state_r != IDLE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a directed vector table for the listed corner
// cases plus randomized stimulus checked by a stream-level reference model.
module tb_inst_fetch_ctrl;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    inst_fetch_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hC0DE_0000 ^ ({22'd0, a} * 32'h9E37_79B1);
    endfunction

    // Synchronous ROM model: one cycle read latency.
    always @(posedge clock) bus.imem_q <= mem_word(bus.imem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC, next expected word address and a coarse mode.
    // Words in flight are the distance between the PC and the next expected
    // address, in steps of 4.
    bit         model_on = 1'b0;
    int         m_mode;          // 0 idle, 1 running, 2 draining
    logic [9:0] m_pc;
    logic [9:0] m_exp;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                model_on = 1'b1;
                m_mode   = 0;
                m_pc     = 10'd0;
                m_exp    = 10'd0;
            end else if (model_on) begin
                logic [9:0] diff;
                int         inflight;
                logic       exp_valid;
                logic       issue;
                diff      = m_pc - m_exp;
                inflight  = int'(diff[9:2]);
                exp_valid = (inflight != 0) && !bus.redirect_valid;
                chk("model_busy", {31'd0, bus.busy}, {31'd0, (m_mode != 0)});
                chk("model_addr", {22'd0, bus.imem_address}, {22'd0, m_pc});
                chk("model_valid", {31'd0, bus.inst_valid}, {31'd0, exp_valid});
                if (exp_valid && !bus.stall) begin
                    chk("model_pc", {22'd0, bus.inst_pc}, {22'd0, m_exp});
                    chk("model_inst", bus.inst, mem_word(m_exp));
                    m_exp = m_exp + 10'd4;
                end
                issue = (m_mode == 1) && !bus.halt_req && !bus.redirect_valid &&
                        !(bus.stall && inflight != 0);
                if (bus.redirect_valid) begin
                    m_pc  = {bus.redirect_pc[9:2], 2'b00};
                    m_exp = {bus.redirect_pc[9:2], 2'b00};
                    if (m_mode == 2) m_mode = 0;
                end else begin
                    if (issue) m_pc = m_pc + 10'd4;
                    if (m_mode == 0 && bus.start) m_mode = 1;
                    else if (m_mode == 1 && bus.halt_req) m_mode = 2;
                    else if (m_mode == 2 && inflight == 0) m_mode = 0;
                end
            end
        end
    end

    typedef struct {
        logic       rst_n, start, halt, stall, rv;
        logic [9:0] rpc;
        logic       e_valid;
        logic [9:0] e_pc;
        logic       e_busy;
        logic [9:0] e_addr;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(input logic r, input logic s, input logic h, input logic st,
                                input logic rv, input logic [9:0] rpc, input logic ev,
                                input logic [9:0] ep, input logic eb, input logic [9:0] ea);
        vec_t v;
        v.rst_n = r; v.start = s; v.halt = h; v.stall = st; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = ep; v.e_busy = eb; v.e_addr = ea;
        return v;
    endfunction

    task automatic drive(input logic r, input logic s, input logic h, input logic st,
                         input logic rv, input logic [9:0] rpc);
        reset_n            = r;
        bus.start          = s;
        bus.halt_req       = h;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        //            rst start halt stall rv rpc        valid pc        busy addr
        tbl[0]  = mk(1, 1, 0, 0, 0, 10'd0,     0, 10'd0,     0, 10'd0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd0,     1, 10'd4);
        tbl[3]  = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd4,     1, 10'd8);
        tbl[4]  = mk(1, 0, 0, 1, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[5]  = mk(1, 0, 0, 1, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[6]  = mk(1, 0, 0, 1, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[7]  = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[8]  = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd12,    1, 10'd16);
        tbl[9]  = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd16,    1, 10'd20);
        tbl[10] = mk(1, 0, 0, 1, 0, 10'd0,     1, 10'd20,    1, 10'd24);
        tbl[11] = mk(1, 0, 0, 1, 1, 10'h103,   0, 10'd0,     1, 10'd24);
        tbl[12] = mk(1, 0, 0, 1, 0, 10'd0,     0, 10'd0,     1, 10'h100);
        tbl[13] = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'h100,   1, 10'h104);
        tbl[14] = mk(1, 0, 0, 0, 1, 10'd1016,  0, 10'd0,     1, 10'h108);
        tbl[15] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd1016);
        tbl[16] = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd1016,  1, 10'd1020);
        tbl[17] = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd1020,  1, 10'd0);
        tbl[18] = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd0,     1, 10'd4);
        tbl[19] = mk(1, 0, 1, 0, 0, 10'd0,     1, 10'd4,     1, 10'd8);
        tbl[20] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd8);
        tbl[21] = mk(1, 1, 0, 0, 0, 10'd0,     0, 10'd0,     0, 10'd8);
        tbl[22] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd8);
        tbl[23] = mk(1, 0, 1, 1, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[24] = mk(1, 0, 0, 0, 0, 10'd0,     1, 10'd8,     1, 10'd12);
        tbl[25] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd12);
        tbl[26] = mk(1, 1, 0, 0, 0, 10'd0,     0, 10'd0,     0, 10'd12);
        tbl[27] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     1, 10'd12);
        tbl[28] = mk(1, 0, 0, 1, 0, 10'd0,     1, 10'd12,    1, 10'd16);
        tbl[29] = mk(0, 0, 0, 1, 0, 10'd0,     1, 10'd12,    1, 10'd16);
        tbl[30] = mk(1, 0, 0, 0, 0, 10'd0,     0, 10'd0,     0, 10'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        repeat (3) @(posedge clock);

        // Directed table: inputs applied after the edge, outputs checked mid-cycle.
        for (int i = 0; i < 31; i++) begin
            @(posedge clock);
            #1;
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].halt, tbl[i].stall, tbl[i].rv, tbl[i].rpc);
            @(negedge clock);
            chk($sformatf("tbl_busy[%0d]", i), {31'd0, bus.busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("tbl_addr[%0d]", i), {22'd0, bus.imem_address}, {22'd0, tbl[i].e_addr});
            chk($sformatf("tbl_valid[%0d]", i), {31'd0, bus.inst_valid}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl_pc[%0d]", i), {22'd0, bus.inst_pc}, {22'd0, tbl[i].e_pc});
                chk($sformatf("tbl_inst[%0d]", i), bus.inst, mem_word(tbl[i].e_pc));
            end
        end

        // Randomized traffic; the reference model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock);
            #1;
            drive(($urandom_range(99) != 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(19) == 0),
                  ($urandom_range(9) < 3),
                  ($urandom_range(24) == 0),
                  10'($urandom_range(1023)));
        end

        @(posedge clock);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
